// File: rtl/game_controller_gen.sv
// ============================================================================
// Module  : game_controller_gen
// Brief   : Two-player modular-cycle move game controller with screen clear.
//           Optional macro GAME_ROUND_TIMEOUT_EN forces a tie on a stalled CHOOSE.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module game_controller_gen #(
   parameter int NUM_CHOICES    = 3,
   parameter int WIN_SCORE      = 3,
   parameter int SCR_W          = 160,
   parameter int SCR_H          = 120,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       lock,
   input  logic       restart,
   input  logic [3:0] p1Choice,
   input  logic [3:0] p2Choice,
   output logic [3:0] p1Score,
   output logic [3:0] p2Score,
   output logic [1:0] roundResult,
   output logic [1:0] winner,
   output logic [2:0] state,
   output logic [7:0] x,
   output logic [7:0] y,
   output logic       paint,
   output logic       choiceErr
);

   typedef enum logic [2:0] {
      S_CLEAR   = 3'd0,
      S_IDLE    = 3'd1,
      S_CHOOSE  = 3'd2,
      S_RESOLVE = 3'd3,
      S_CHECK   = 3'd4,
      S_WIN     = 3'd5
   } state_t;

   localparam logic [7:0] c_x_last = 8'(SCR_W - 1);
   localparam logic [7:0] c_y_last = 8'(SCR_H - 1);
   localparam logic [3:0] c_win    = 4'(WIN_SCORE);
   localparam logic [4:0] c_n      = 5'(NUM_CHOICES);
   localparam logic [4:0] c_half   = 5'((NUM_CHOICES - 1) / 2);

   if ((NUM_CHOICES < 3) || (NUM_CHOICES > 15) || ((NUM_CHOICES % 2) == 0) ||
       (WIN_SCORE < 1) || (WIN_SCORE > 15) || (SCR_W < 1) || (SCR_W > 256) ||
       (SCR_H < 1) || (SCR_H > 256) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
      $error("game_controller_gen: parameter out of range");
   end

   state_t     r_state;
   logic       r_lock_q;
   logic [3:0] r_c1;
   logic [3:0] r_c2;

   logic       w_lock_edge;
   logic       w_choice_ok;
   logic       w_accept;
   logic [4:0] w_diff;
   logic [1:0] w_result;
   logic       w_timeout;
   logic       w_force_tie;

   assign w_lock_edge = lock & ~r_lock_q;
   assign w_choice_ok = ({1'b0, p1Choice} < c_n) && ({1'b0, p2Choice} < c_n);
   assign w_accept    = (r_state == S_CHOOSE) && w_lock_edge && w_choice_ok;

   // (p1 - p2) mod N without a divider: both operands are already below N
   assign w_diff   = (r_c1 >= r_c2) ? ({1'b0, r_c1} - {1'b0, r_c2})
                                    : ({1'b0, r_c1} + c_n - {1'b0, r_c2});
   assign w_result = (w_diff == 5'd0)  ? 2'b11 :
                     (w_diff <= c_half) ? 2'b01 : 2'b10;

`ifdef GAME_ROUND_TIMEOUT_EN
   localparam int c_tw = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_tw-1:0] c_t_last = c_tw'(TIMEOUT_CYCLES - 1);

   logic [c_tw-1:0] r_tmo_cnt;
   logic            r_force_tie;

   assign w_timeout   = (r_state == S_CHOOSE) && (r_tmo_cnt == c_t_last);
   assign w_force_tie = r_force_tie;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tmo_cnt   <= '0;
         r_force_tie <= 1'b0;
      end else begin
         r_force_tie <= w_timeout && !w_accept;
         if ((r_state != S_CHOOSE) || w_accept || w_timeout)
            r_tmo_cnt <= '0;
         else
            r_tmo_cnt <= r_tmo_cnt + c_tw'(1);
      end
   end
`else
   assign w_timeout   = 1'b0;
   assign w_force_tie = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_CLEAR;
         r_lock_q    <= 1'b0;
         r_c1        <= 4'd0;
         r_c2        <= 4'd0;
         p1Score     <= 4'd0;
         p2Score     <= 4'd0;
         roundResult <= 2'b00;
         winner      <= 2'b00;
         x           <= 8'd0;
         y           <= 8'd0;
         paint       <= 1'b0;
         choiceErr   <= 1'b0;
      end else begin
         r_lock_q  <= lock;
         choiceErr <= 1'b0;
         case (r_state)
            S_CLEAR: begin
               // paint is low only in the first cycle after reset release
               if (!paint) begin
                  paint <= 1'b1;
               end else if ((x == c_x_last) && (y == c_y_last)) begin
                  paint   <= 1'b0;
                  x       <= 8'd0;
                  y       <= 8'd0;
                  r_state <= S_IDLE;
               end else if (x == c_x_last) begin
                  x <= 8'd0;
                  y <= y + 8'd1;
               end else begin
                  x <= x + 8'd1;
               end
            end
            S_IDLE: begin
               if (start) r_state <= S_CHOOSE;
            end
            S_CHOOSE: begin
               if (w_lock_edge) begin
                  if (w_choice_ok) begin
                     r_c1    <= p1Choice;
                     r_c2    <= p2Choice;
                     r_state <= S_RESOLVE;
                  end else begin
                     choiceErr <= 1'b1;
                  end
               end else if (w_timeout) begin
                  r_state <= S_RESOLVE;
               end
            end
            S_RESOLVE: begin
               r_state <= S_CHECK;
               if (w_force_tie) begin
                  roundResult <= 2'b11;
               end else begin
                  roundResult <= w_result;
                  if ((w_result == 2'b01) && (p1Score < c_win)) p1Score <= p1Score + 4'd1;
                  if ((w_result == 2'b10) && (p2Score < c_win)) p2Score <= p2Score + 4'd1;
               end
            end
            S_CHECK: begin
               if (p1Score == c_win) begin
                  winner  <= 2'b01;
                  r_state <= S_WIN;
               end else if (p2Score == c_win) begin
                  winner  <= 2'b10;
                  r_state <= S_WIN;
               end else begin
                  r_state <= S_CHOOSE;
               end
            end
            S_WIN: begin
               if (restart) begin
                  r_state     <= S_CLEAR;
                  paint       <= 1'b1;
                  x           <= 8'd0;
                  y           <= 8'd0;
                  p1Score     <= 4'd0;
                  p2Score     <= 4'd0;
                  roundResult <= 2'b00;
                  winner      <= 2'b00;
               end
            end
            default: begin
               r_state     <= S_CLEAR;
               paint       <= 1'b1;
               x           <= 8'd0;
               y           <= 8'd0;
               p1Score     <= 4'd0;
               p2Score     <= 4'd0;
               roundResult <= 2'b00;
               winner      <= 2'b00;
            end
         endcase
      end
   end

   assign state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_game_controller_gen.sv
// ============================================================================
// Module  : tb_game_controller_gen
// Brief   : Scoreboard bench for game_controller_gen (SCR_W=4, SCR_H=2, N=3).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_controller_gen;

   localparam int NC = 3;
   localparam int WS = 3;
   localparam int W  = 4;
   localparam int H  = 2;
`ifdef GAME_ROUND_TIMEOUT_EN
   localparam int TMO  = 5;
   localparam int HOLD = 3;
`else
   localparam int TMO  = 1000;
   localparam int HOLD = 10;
`endif

   logic       clk;
   logic       reset;
   logic       start;
   logic       lock;
   logic       restart;
   logic [3:0] p1c;
   logic [3:0] p2c;
   logic [3:0] p1Score;
   logic [3:0] p2Score;
   logic [1:0] roundResult;
   logic [1:0] winner;
   logic [2:0] state;
   logic [7:0] x;
   logic [7:0] y;
   logic       paint;
   logic       choiceErr;

   game_controller_gen #(
      .NUM_CHOICES(NC), .WIN_SCORE(WS), .SCR_W(W), .SCR_H(H), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .lock(lock), .restart(restart),
      .p1Choice(p1c), .p2Choice(p2c), .p1Score(p1Score), .p2Score(p2Score),
      .roundResult(roundResult), .winner(winner), .state(state),
      .x(x), .y(y), .paint(paint), .choiceErr(choiceErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [1:0] rr;
      logic [3:0] s1;
      logic [3:0] s2;
   } exp_t;

   exp_t       q_round[$];
   logic [2:0] q_err[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Monitor: every CHECK cycle presents a freshly registered round outcome
   always @(negedge clk) begin
      if (reset) begin
         if (state == 3'd4) begin
            if (q_round.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_round: got %0h with no pending round", {roundResult, p1Score, p2Score});
            end else begin
               exp_t e;
               e = q_round.pop_front();
               check("round_outcome", 32'({roundResult, p1Score, p2Score}), 32'(e));
            end
         end
         if (choiceErr) begin
            if (q_err.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_choiceErr: got 1 expected 0 in state %0d", state);
            end else begin
               logic [2:0] es;
               es = q_err.pop_front();
               check("choiceErr_state", 32'(state), 32'(es));
            end
         end
      end
   end

   task automatic sweep(input string nm);
      for (int i = 0; i < W * H; i++) begin
         tick();
         check(nm, 32'({paint, state, x, y}), 32'({1'b1, 3'd0, 8'(i % W), 8'(i / W)}));
      end
      tick();
      check({nm, "_done"}, 32'({paint, state, x, y}), 32'({1'b0, 3'd1, 16'd0}));
   endtask

   task automatic play_round(input logic [3:0] a, input logic [3:0] b, input logic [1:0] rr,
                             input logic [3:0] s1, input logic [3:0] s2,
                             input logic [2:0] st, input int hold);
      exp_t e;
      e.rr = rr; e.s1 = s1; e.s2 = s2;
      q_round.push_back(e);
      p1c  = a;
      p2c  = b;
      lock = 1'b1;
      tick();
      check("resolve_state", 32'(state), 32'd3);
      if (hold <= 1) lock = 1'b0;
      tick();
      tick();
      check("post_round_state", 32'(state), 32'(st));
      if (hold > 1) begin
         repeat (hold - 3) tick();
         lock = 1'b0;
         tick();
         check("post_hold_state", 32'(state), 32'(st));
      end
   endtask

   task automatic err_test(input logic [3:0] a, input logic [3:0] b);
      q_err.push_back(3'd2);
      p1c  = a;
      p2c  = b;
      lock = 1'b1;
      tick();
      check("err_stay_choose", 32'(state), 32'd2);
      lock = 1'b0;
      tick();
      check("err_one_cycle", 32'({choiceErr, state}), 32'({1'b0, 3'd2}));
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; lock = 1'b0; restart = 1'b0; p1c = 4'd0; p2c = 4'd0;
      tick();
      tick();
      check("reset_outputs", 32'({p1Score, p2Score, roundResult, winner, state, paint, choiceErr}), 32'd0);
      check("reset_xy", 32'({x, y}), 32'd0);
      reset = 1'b1;
      sweep("sweep_after_reset");

      lock = 1'b1;
      tick();
      lock = 1'b0;
      tick();
      check("idle_ignores_lock", 32'(state), 32'd1);

      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_to_choose", 32'(state), 32'd2);

      play_round(4'd1, 4'd0, 2'b01, 4'd1, 4'd0, 3'd2, 1);
      play_round(4'd2, 4'd2, 2'b11, 4'd1, 4'd0, 3'd2, 1);
      err_test(4'd3, 4'd0);
      err_test(4'd0, 4'd4);
      play_round(4'd0, 4'd1, 2'b10, 4'd1, 4'd1, 3'd2, HOLD);
      play_round(4'd0, 4'd1, 2'b10, 4'd1, 4'd2, 3'd2, 1);
      play_round(4'd0, 4'd1, 2'b10, 4'd1, 4'd3, 3'd5, 1);
      check("win_hold", 32'({winner, p1Score, p2Score}), 32'({2'b10, 4'd1, 4'd3}));

      start = 1'b1;
      lock  = 1'b1;
      tick();
      start = 1'b0;
      lock  = 1'b0;
      tick();
      check("win_ignores_start_lock", 32'({state, winner, p2Score}), 32'({3'd5, 2'b10, 4'd3}));

      restart = 1'b1;
      tick();
      restart = 1'b0;
      check("restart_clears", 32'({state, paint, x, y, p1Score, p2Score, roundResult, winner}),
            32'({3'd0, 1'b1, 16'd0, 12'd0}));
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("async_reset_mid_clear", 32'({paint, state, x, y, p1Score, p2Score}), 32'd0);
      tick();
      reset = 1'b1;
      sweep("sweep_after_mid_reset");

      start = 1'b1;
      tick();
      start = 1'b0;
      check("second_start", 32'(state), 32'd2);
`ifdef GAME_ROUND_TIMEOUT_EN
      begin
         exp_t e;
         e.rr = 2'b11; e.s1 = 4'd0; e.s2 = 4'd0;
         q_round.push_back(e);
      end
      repeat (4) tick();
      check("timeout_still_choose", 32'(state), 32'd2);
      tick();
      check("timeout_resolve", 32'(state), 32'd3);
      tick();
      tick();
      check("timeout_back_to_choose", 32'(state), 32'd2);
`else
      repeat (20) tick();
      check("choose_waits", 32'({state, roundResult, choiceErr}), 32'({3'd2, 2'b00, 1'b0}));
`endif

      check("round_queue_drained", 32'(q_round.size()), 32'd0);
      check("err_queue_drained", 32'(q_err.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
